// File: rtl/mg4bit_serial.sv
// rtl/mg4bit_serial.sv - bit-serial MSB-first magnitude comparator with start/done framing
module mg4bit_serial #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic x,
    output logic y,
    output logic z
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          gt;
    logic          lt;
    logic          nxt_gt;
    logic          nxt_lt;

    // Decision after the current pair: the first differing bit (MSB-first) settles it for good.
    always_comb begin
        nxt_gt = gt;
        nxt_lt = lt;
        if (!(gt | lt)) begin
            nxt_gt = a_bit & ~b_bit;
            nxt_lt = ~a_bit & b_bit;
        end
    end

    // Framing FSM: consume WIDTH valid pairs after start, then publish x/y/z with a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            x     <= 1'b0;
            y     <= 1'b0;
            z     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        cnt <= cnt + 1'b1;
                        gt  <= nxt_gt;
                        lt  <= nxt_lt;
                        if (cnt == LAST) begin
                            x     <= nxt_gt;
                            y     <= ~(nxt_gt | nxt_lt);
                            z     <= nxt_lt;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mg4bit_serial.sv
// tb/tb_mg4bit_serial.sv - randomized self-checking bench for mg4bit_serial
module tb_mg4bit_serial;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic x;
    logic y;
    logic z;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mg4bit_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .x         (x),
        .y         (y),
        .z         (z)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result: plain unsigned comparison of the whole operands.
    function automatic logic [2:0] ref_xyz(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a > b, a == b, a < b};
    endfunction

    // Drives one framed comparison starting in the current cycle; returns what was observed.
    task automatic drive_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int stall_at, input int stall_len, input bit poke_start,
                             output int done_cyc, output logic [2:0] xyz,
                             output bit busy_bad, output bit hold_bad);
        logic [2:0] held;
        int bi;
        int stalls;
        int cyc;
        held      = {x, y, z};
        done_cyc  = -1;
        xyz       = 3'bxxx;
        busy_bad  = 1'b0;
        hold_bad  = 1'b0;
        bi        = 0;
        stalls    = 0;
        start     = 1'b1;
        bit_valid = 1'($urandom);
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 40) begin
            if (done) begin
                done_cyc = cyc;
                xyz      = {x, y, z};
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if ({x, y, z} !== held) hold_bad = 1'b1;
            if (bi == stall_at && stalls < stall_len) begin
                bit_valid = 1'b0;
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
                stalls++;
            end else if (bi < W) begin
                bit_valid = 1'b1;
                a_bit     = a[W-1-bi];
                b_bit     = b[W-1-bi];
                bi++;
            end else begin
                bit_valid = 1'b1;
                a_bit     = 1'($urandom);
                b_bit     = 1'($urandom);
            end
            start = poke_start ? 1'($urandom) : 1'b0;
            tick();
            cyc++;
        end
        start     = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start     = 1'b0;
            bit_valid = 1'($urandom);
            a_bit     = 1'($urandom);
            b_bit     = 1'($urandom);
            tick();
        end
    endtask

    // Shared check sequence written out per test to keep each scenario self-contained.
    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'($urandom); a_bit = 1'($urandom); b_bit = 1'($urandom);
            tick();
            n_cmp++;
            if ({busy, done, x, y, z} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_hold: busy/done/x/y/z=%b required 00000", {busy, done, x, y, z});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle_cycles(1);
            n_cmp++;
            if ({busy, done, x, y, z} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: busy/done/x/y/z=%b required 00000", i, {busy, done, x, y, z});
            end
        end
    endtask

    task automatic test_greater();
        int dc; logic [2:0] r; bit bb, hb;
        drive_cmp(4'b1111, 4'b1101, -1, 0, 1'b0, dc, r, bb, hb);
        n_cmp++;
        if (dc !== W + 1) begin n_fail++; $display("FAIL greater_latency: done cycle %0d required %0d", dc, W + 1); end
        n_cmp++;
        if (r !== 3'b100) begin n_fail++; $display("FAIL greater_xyz: %b required 100", r); end
        n_cmp++;
        if (bb || busy !== 1'b0) begin n_fail++; $display("FAIL greater_busy: gap=%0d busy_in_done=%b required 0/0", bb, busy); end
        idle_cycles(1);
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL greater_done_width: done=%b required 0", done); end
    endtask

    task automatic test_less_equal_b2b();
        int dc; logic [2:0] r; bit bb, hb;
        drive_cmp(4'b0000, 4'b0101, -1, 0, 1'b0, dc, r, bb, hb);
        n_cmp++;
        if (r !== 3'b001 || dc !== W + 1) begin n_fail++; $display("FAIL less_xyz: %b at %0d required 001 at %0d", r, dc, W + 1); end
        drive_cmp(4'b0110, 4'b0110, -1, 0, 1'b0, dc, r, bb, hb);
        n_cmp++;
        if (r !== 3'b010 || dc !== W + 1) begin n_fail++; $display("FAIL b2b_equal: %b at %0d required 010 at %0d", r, dc, W + 1); end
        n_cmp++;
        if (hb || bb) begin n_fail++; $display("FAIL b2b_hold: hold_changed=%0d busy_gap=%0d required 0/0", hb, bb); end
        idle_cycles(2);
    endtask

    task automatic test_stall_ignored_start();
        int dc; logic [2:0] r; bit bb, hb;
        drive_cmp(4'b1100, 4'b1010, 2, 2, 1'b1, dc, r, bb, hb);
        n_cmp++;
        if (dc !== W + 3) begin n_fail++; $display("FAIL stall_latency: done cycle %0d required %0d", dc, W + 3); end
        n_cmp++;
        if (r !== 3'b100 || bb) begin n_fail++; $display("FAIL stall_xyz: %b busy_gap=%0d required 100/0", r, bb); end
        idle_cycles(1);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL stall_no_restart: busy=%b done=%b required 0/0", busy, done); end
    endtask

    task automatic test_frozen();
        int dc; logic [2:0] r; bit bb, hb;
        drive_cmp(4'b1000, 4'b0111, -1, 0, 1'b0, dc, r, bb, hb);
        n_cmp++;
        if (r !== 3'b100 || dc !== W + 1) begin n_fail++; $display("FAIL frozen_xyz: %b at %0d required 100 at %0d", r, dc, W + 1); end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        int dc; logic [2:0] r; bit bb, hb;
        logic [3:0] a, b;
        bit seen_done;
        a = 4'b0011; b = 4'b0001;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1; a_bit = a[3-i]; b_bit = b[3-i]; tick();
        end
        rst = 1'b1; bit_valid = 1'b1; a_bit = a[1]; b_bit = b[1];
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, x, y, z} !== 5'b0) begin n_fail++; $display("FAIL rst_mid: busy/done/x/y/z=%b required 00000", {busy, done, x, y, z}); end
        seen_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom); tick();
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done) begin n_fail++; $display("FAIL rst_mid_no_done: activity=1 required 0"); end
        drive_cmp(a, b, -1, 0, 1'b0, dc, r, bb, hb);
        n_cmp++;
        if (r !== 3'b100 || dc !== W + 1) begin n_fail++; $display("FAIL rst_mid_redo: %b at %0d required 100 at %0d", r, dc, W + 1); end
        idle_cycles(1);
        // reset coinciding with start
        rst = 1'b1; start = 1'b1; tick();
        rst = 1'b0; start = 1'b0; tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_vs_start: busy=%b required 0", busy); end
        // reset coinciding with the final bit
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom); tick();
        end
        rst = 1'b1; bit_valid = 1'b1; tick();
        rst = 1'b0; bit_valid = 1'b0;
        n_cmp++;
        if ({busy, done, x, y, z} !== 5'b0) begin n_fail++; $display("FAIL rst_vs_final: busy/done/x/y/z=%b required 00000", {busy, done, x, y, z}); end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_vs_final_late: done=%b required 0", done); end
    endtask

    task automatic test_random();
        int dc; logic [2:0] r; bit bb, hb;
        logic [W-1:0] a, b;
        int sa, sl;
        for (int t = 0; t < 24; t++) begin
            a  = W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            sa = $urandom_range(0, W - 1);
            sl = $urandom_range(0, 3);
            drive_cmp(a, b, sa, sl, 1'($urandom), dc, r, bb, hb);
            n_cmp++;
            if (r !== ref_xyz(a, b) || dc !== W + 1 + sl || bb || hb) begin
                n_fail++;
                $display("FAIL random[%0d]: a=%b b=%b xyz=%b at %0d gap=%0d hold=%0d required %b at %0d",
                         t, a, b, r, dc, bb, hb, ref_xyz(a, b), W + 1 + sl);
            end
            if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        test_reset();
        test_greater();
        test_less_equal_b2b();
        test_stall_ignored_start();
        test_frozen();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mg4bit_serial.md
# mg4bit_serial

Bit-serial magnitude comparator. It receives two WIDTH-bit operands MSB-first, one bit pair per accepted cycle, and reports the same x/y/z greater/equal/less result as the parallel 4-bit comparator. It sits on the serial side of the datapath, where operands arrive over a shift link rather than as parallel buses. A start/done handshake frames each comparison.

## Interface
- WIDTH, 4, operand width in bits (≥2); the bit counter is $clog2(WIDTH) bits wide.
- Clocking: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a new comparison; sampled only in IDLE
- bit_valid  input  1  a_bit/b_bit carry a valid operand bit pair this cycle
- a_bit  input  1  serial bit of operand a, MSB first
- b_bit  input  1  serial bit of operand b, MSB first
- busy  output  1  comparison in progress (state SHIFT)
- done  output  1  one-cycle pulse; x/y/z updated this cycle
- x  output  1  a > b (last completed comparison)
- y  output  1  a == b
- z  output  1  a < b

## Operation
- States:
  - IDLE: rst value.
  - SHIFT: counting bit pairs.
- Internal registers:
  - cnt: bit counter.
  - gt, lt: decision flags.
- IDLE:
  - start=1 → SHIFT; cnt=0, gt=0, lt=0.
  - bit_valid is ignored in IDLE and in the start cycle.
- SHIFT:
  - On each edge with bit_valid=1, one pair is consumed and cnt increments.
  - If gt=0 and lt=0: gt ← a_bit & ~b_bit, lt ← ~a_bit & b_bit.
  - Once gt or lt is set, the decision is frozen. Remaining bits are still counted but do not alter it.
  - bit_valid=0 stalls: no count, no update, no timeout.
- Final pair (cnt == WIDTH-1 with bit_valid=1), same edge:
  - x ← final gt, z ← final lt, y ← ~(final gt | final lt). The final pair's own contribution is included.
  - done ← 1 and state → IDLE.
- start asserted while in SHIFT is ignored; no restart.
- x/y/z hold their value until the next done. They are exactly one-hot after the first done.
- Arithmetic is unsigned. Only the counter wraps, and it is reloaded on start.
- rst at any time, including mid-comparison:
  - Every register returns to its reset value next edge.
  - The partial comparison is discarded and no done is produced.

## Timing
- Reset values: busy=0, done=0, x=0, y=0, z=0, state=IDLE, cnt=0, gt=0, lt=0.
- Outputs are registered only; there is no combinational path from inputs to outputs.
- Start accepted at edge k → busy=1 from edge k.
- With continuous bit_valid:
  - Bits are consumed at edges k+1 … k+WIDTH.
  - After edge k+WIDTH: done=1, x/y/z valid, busy=0.
  - Start-to-done latency is WIDTH+1 cycles.
- Each stalled cycle adds exactly one cycle of latency.
- done is high for exactly one cycle. The state is IDLE during that cycle.
- start=1 in the done cycle is accepted, giving back-to-back operation with a throughput of one comparison per WIDTH+1 cycles.
- Simultaneous rst and start: rst wins.
- Simultaneous rst and final bit: rst wins; no done.

## Test plan
- Reset:
  - Stimulus: hold rst 2 cycles, then idle with random a_bit/b_bit/bit_valid and start=0.
  - Required: busy=done=x=y=z=0 throughout.
- Greater, WIDTH=4:
  - Stimulus: start, then a=1111, b=1101 MSB-first, continuous bit_valid.
  - Required: done at cycle 5 after start; x=1, y=0, z=0; busy high for cycles 1–4.
- Less and equal, back-to-back:
  - Stimulus: a=0000, b=0101, then start in the done cycle, then a=0110, b=0110.
  - Required: first done gives z=1; second done gives y=1, 5 cycles later.
  - Required: x/y/z hold z=1 values between the two done pulses.
- Stalls and ignored start:
  - Stimulus: a=1100, b=1010 with bit_valid low for 2 cycles after the second bit; start pulsed during SHIFT.
  - Required: done at cycle 7; x=1; the extra start has no effect.
- Early decision then frozen:
  - Stimulus: a=1000, b=0111.
  - Required: x=1 even though all later bits have b greater.
- Reset mid-operation:
  - Stimulus: assert rst after 2 bits of a=0011, b=0001.
  - Required: busy=0 and x=y=z=0 next cycle; no done.
  - Required: a following start with a=0011, b=0001 gives x=1.
